// File: rtl/keypad_scanner_if.sv
// Key-matrix and key-event signals shared between the keypad scanner (master)
// and the matrix / event consumer side (slave).
interface keypad_scanner_if;
    logic [4:0] col;
    logic [3:0] row;
    logic       newhex;
    logic [3:0] hexcode;
    logic       newop;
    logic [1:0] opcode;
    logic       eq;

    modport master (
        input  col,
        output row, newhex, hexcode, newop, opcode, eq
    );

    modport slave (
        output col,
        input  row, newhex, hexcode, newop, opcode, eq
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x5 key-matrix scanner: row-at-a-time scan, per-frame debounce, one strobe per press.
// Define KEY_REPEAT_EN to enable auto-repeat of held hex keys.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_DELAY   = 50,
    parameter int unsigned REPEAT_RATE    = 10
) (
    input  logic              clock,
    input  logic              reset,
    keypad_scanner_if.master  kp
);
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_TARGET = DB_W'(DEBOUNCE_SCANS);

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("keypad_scanner: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

    logic [4:0]       r_col_meta, r_col_sync;
    logic [DIV_W-1:0] r_div_cnt;
    logic [1:0]       r_row_idx;
    logic [1:0]       r_acc_cnt;
    logic [4:0]       r_acc_code;

    state_t           r_state, w_state_nxt;
    logic [4:0]       r_cand, w_cand_nxt;
    logic [DB_W-1:0]  r_db_cnt, w_db_nxt;

    logic             r_newhex, r_newop, r_eq;
    logic [3:0]       r_hexcode;
    logic [1:0]       r_opcode;

    logic             w_sample, w_frame_done, w_is_key, w_is_none;
    logic [4:0]       w_act;
    logic [2:0]       w_row_cnt, w_col_pos, w_sum;
    logic [4:0]       w_row_code, w_base_code, w_frame_code;
    logic [1:0]       w_base_cnt, w_frame_cnt;
    logic             w_emit;
    logic [4:0]       w_emit_code;

`ifdef KEY_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_RATE  = REP_W'(REPEAT_RATE);
    logic [REP_W-1:0] r_rep_cnt, w_rep_cnt_nxt;
    logic             r_rep_armed, w_rep_armed_nxt;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_col_meta <= '1;
            r_col_sync <= '1;
            r_div_cnt  <= '0;
            r_row_idx  <= '0;
            r_acc_cnt  <= '0;
            r_acc_code <= '0;
        end else begin
            r_col_meta <= kp.col;
            r_col_sync <= r_col_meta;
            if (r_div_cnt == DIV_LAST) begin
                r_div_cnt <= '0;
                r_row_idx <= r_row_idx + 2'd1;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
            if (w_sample) begin
                r_acc_cnt  <= w_frame_cnt;
                r_acc_code <= w_frame_code;
            end
        end
    end

    assign kp.row       = ~(4'b0001 << r_row_idx);
    assign w_sample     = (r_div_cnt == DIV_LAST);
    assign w_frame_done = w_sample && (r_row_idx == 2'd3);
    assign w_act        = ~r_col_sync;

    // Row 0 starts a fresh frame, so the running tally is ignored there.
    always_comb begin
        w_row_cnt = '0;
        w_col_pos = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            w_row_cnt = w_row_cnt + 3'(w_act[i]);
        end
        for (int unsigned i = 5; i > 0; i--) begin
            if (w_act[i-1]) w_col_pos = 3'(i - 1);
        end
        w_row_code   = w_col_pos[2] ? {3'b100, r_row_idx} : {1'b0, r_row_idx, w_col_pos[1:0]};
        w_base_cnt   = (r_row_idx == 2'd0) ? 2'd0 : r_acc_cnt;
        w_base_code  = (r_row_idx == 2'd0) ? 5'd0 : r_acc_code;
        w_sum        = {1'b0, w_base_cnt} + w_row_cnt;
        w_frame_cnt  = (w_sum > 3'd2) ? 2'd2 : w_sum[1:0];
        w_frame_code = (w_base_cnt == 2'd0) ? w_row_code : w_base_code;
    end

    assign w_is_key  = (w_frame_cnt == 2'd1);
    assign w_is_none = (w_frame_cnt == 2'd0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cand   <= '0;
            r_db_cnt <= '0;
`ifdef KEY_REPEAT_EN
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_cand   <= w_cand_nxt;
            r_db_cnt <= w_db_nxt;
`ifdef KEY_REPEAT_EN
            r_rep_cnt   <= w_rep_cnt_nxt;
            r_rep_armed <= w_rep_armed_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_db_nxt    = r_db_cnt;
        w_emit      = 1'b0;
        w_emit_code = r_cand;
`ifdef KEY_REPEAT_EN
        w_rep_cnt_nxt   = (r_state == HELD) ? r_rep_cnt : '0;
        w_rep_armed_nxt = (r_state == HELD) ? r_rep_armed : 1'b0;
`endif
        if (w_frame_done) begin
            unique case (r_state)
                IDLE: begin
                    if (w_is_key) begin
                        w_cand_nxt  = w_frame_code;
                        w_emit_code = w_frame_code;
                        w_db_nxt    = DB_W'(1);
                        if (DB_TARGET == DB_W'(1)) begin
                            w_emit      = 1'b1;
                            w_state_nxt = HELD;
                        end else begin
                            w_state_nxt = PRESS_DB;
                        end
                    end
                end
                PRESS_DB: begin
                    if (w_is_key && w_frame_code == r_cand) begin
                        w_db_nxt = r_db_cnt + DB_W'(1);
                        if (w_db_nxt == DB_TARGET) begin
                            w_emit      = 1'b1;
                            w_state_nxt = HELD;
                        end
                    end else if (w_is_key) begin
                        w_cand_nxt = w_frame_code;
                        w_db_nxt   = DB_W'(1);
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                HELD: begin
                    if (w_is_none) begin
                        w_db_nxt    = DB_W'(1);
                        w_state_nxt = (DB_TARGET == DB_W'(1)) ? IDLE : REL_DB;
                    end
`ifdef KEY_REPEAT_EN
                    // Delay phase until the first repeat, then rate phase; any other frame re-arms the delay.
                    if (w_is_key && w_frame_code == r_cand && !r_cand[4]) begin
                        w_rep_cnt_nxt = r_rep_cnt + REP_W'(1);
                        if ((!r_rep_armed && w_rep_cnt_nxt == REP_DELAY) ||
                            ( r_rep_armed && w_rep_cnt_nxt == REP_RATE)) begin
                            w_emit          = 1'b1;
                            w_rep_cnt_nxt   = '0;
                            w_rep_armed_nxt = 1'b1;
                        end
                    end else begin
                        w_rep_cnt_nxt   = '0;
                        w_rep_armed_nxt = 1'b0;
                    end
`endif
                end
                REL_DB: begin
                    if (w_is_none) begin
                        w_db_nxt = r_db_cnt + DB_W'(1);
                        if (w_db_nxt == DB_TARGET) w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = HELD;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_newhex  <= 1'b0;
            r_newop   <= 1'b0;
            r_eq      <= 1'b0;
            r_hexcode <= '0;
            r_opcode  <= '0;
        end else begin
            r_newhex <= 1'b0;
            r_newop  <= 1'b0;
            r_eq     <= 1'b0;
            if (w_emit) begin
                if (!w_emit_code[4]) begin
                    r_newhex  <= 1'b1;
                    r_hexcode <= w_emit_code[3:0];
                end else if (w_emit_code[1:0] == 2'd3) begin
                    r_eq <= 1'b1;
                end else begin
                    r_newop  <= 1'b1;
                    r_opcode <= w_emit_code[1:0];
                end
            end
        end
    end

    assign kp.newhex  = r_newhex;
    assign kp.newop   = r_newop;
    assign kp.eq      = r_eq;
    assign kp.hexcode = r_hexcode;
    assign kp.opcode  = r_opcode;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed key sequences plus random key frames,
// every cycle compared against a frame-level run-length model of the debounce rules.
`timescale 1ns/1ps
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DS = 2;
    localparam int RD = 3;
    localparam int RR = 2;
    localparam int FRAME = 4 * SD;
`ifdef KEY_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [19:0] keys = '0;

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_DIV(SD),
        .DEBOUNCE_SCANS(DS),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .kp(kp)
    );

    always #5 clock = ~clock;

    function automatic int code_of(int r, int c);
        return (c < 4) ? (4 * r + c) : (16 + r);
    endfunction

    // Key matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        kp.col = 5'b11111;
        for (int r = 0; r < 4; r++) begin
            if (!kp.row[r]) begin
                for (int c = 0; c < 5; c++) begin
                    if (keys[code_of(r, c)]) kp.col[c] = 1'b0;
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int pos = 0;
    int act_hex = 0, act_op = 0, act_eq = 0;

    bit m_held;
    int m_cand, m_streak, m_nstreak, m_run;
    logic [3:0] m_hexcode;
    logic [1:0] m_opcode;
    int pend_kind;
    int pend_code;

    task automatic model_reset();
        m_held = 1'b0; m_cand = -1; m_streak = 0; m_nstreak = 0; m_run = 0;
        m_hexcode = '0; m_opcode = '0; pend_kind = 0; pend_code = 0;
    endtask

    task automatic fire(int code);
        pend_code = code;
        pend_kind = (code < 16) ? 1 : (code == 19) ? 3 : 2;
    endtask

    // Frame result: -1 no key, -2 several keys, else the single key code.
    task automatic model_frame(input logic [19:0] mask);
        int res, n;
        n = $countones(mask);
        res = (n == 0) ? -1 : -2;
        if (n == 1) for (int i = 0; i < 20; i++) if (mask[i]) res = i;
        if (!m_held) begin
            if (res >= 0 && res == m_cand && m_streak > 0) m_streak++;
            else if (res >= 0) begin m_cand = res; m_streak = 1; end
            else m_streak = 0;
            if (m_streak == DS) begin
                m_held = 1'b1; m_streak = 0; m_nstreak = 0; m_run = 0;
                fire(m_cand);
            end
        end else begin
            if (res == -1) begin
                m_nstreak++; m_run = 0;
                if (m_nstreak == DS) begin m_held = 1'b0; m_streak = 0; end
            end else if (res == m_cand && m_nstreak == 0) begin
                m_run++;
                if (REP_ON && m_cand < 16 &&
                    (m_run == RD || (m_run > RD && (m_run - RD) % RR == 0))) fire(m_cand);
            end else begin
                m_nstreak = 0; m_run = 0;
            end
        end
    endtask

    task automatic step();
        logic [12:0] exp_v, got_v;
        @(negedge clock);
        if (pos == 0 && pend_kind == 1) m_hexcode = pend_code[3:0];
        if (pos == 0 && pend_kind == 2) m_opcode = pend_code[1:0];
        exp_v = {pos == 0 && pend_kind == 1, pos == 0 && pend_kind == 2, pos == 0 && pend_kind == 3,
                 m_hexcode, m_opcode, ~(4'b0001 << ((pos / SD) % 4))};
        got_v = {kp.newhex, kp.newop, kp.eq, kp.hexcode, kp.opcode, kp.row};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL cycle t=%0t pos=%0d {newhex,newop,eq,hexcode,opcode,row} got=%b required=%b",
                     $time, pos, got_v, exp_v);
        end
        if (kp.newhex === 1'b1) act_hex++;
        if (kp.newop === 1'b1) act_op++;
        if (kp.eq === 1'b1) act_eq++;
        if (pos == 0) pend_kind = 0;
        if (pos == FRAME - 1) model_frame(keys);
        @(posedge clock);
        #1;
        pos = (pos + 1) % FRAME;
    endtask

    task automatic run(input logic [19:0] mask, input int frames);
        keys = mask;
        repeat (frames * FRAME) step();
    endtask

    task automatic do_reset();
        logic [12:0] got_v;
        #2 reset = 1'b0;
        #3;
        got_v = {kp.newhex, kp.newop, kp.eq, kp.hexcode, kp.opcode, kp.row};
        checks++;
        if (got_v !== 13'b000_0000_00_1110) begin
            errors++;
            $display("FAIL reset_state got=%b required=%b", got_v, 13'b000_0000_00_1110);
        end
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        model_reset();
        pos = 0;
        step();
    endtask

    task automatic check_int(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    typedef struct {
        logic [19:0] mask;
        int          frames;
        int          n_hex;
        int          n_op;
        int          n_eq;
        logic [3:0]  hc;
        logic [1:0]  oc;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int bh, bo, be;
        logic [19:0] rmask;
        tbl[0]  = '{20'h00040,  5, REP_ON ? 2 : 1, 0, 0, 4'h6, 2'd0};
        tbl[1]  = '{20'h00000,  3, 0, 0, 0, 4'h6, 2'd0};
        tbl[2]  = '{20'h00400,  1, 0, 0, 0, 4'h6, 2'd0};
        tbl[3]  = '{20'h00000,  1, 0, 0, 0, 4'h6, 2'd0};
        tbl[4]  = '{20'h00400,  3, 1, 0, 0, 4'hA, 2'd0};
        tbl[5]  = '{20'h00000,  3, 0, 0, 0, 4'hA, 2'd0};
        tbl[6]  = '{20'h40000,  3, 0, 1, 0, 4'hA, 2'd2};
        tbl[7]  = '{20'h00000,  3, 0, 0, 0, 4'hA, 2'd2};
        tbl[8]  = '{20'h80000,  3, 0, 0, 1, 4'hA, 2'd2};
        tbl[9]  = '{20'h00000,  3, 0, 0, 0, 4'hA, 2'd2};
        tbl[10] = '{20'h00022,  4, 0, 0, 0, 4'hA, 2'd2};
        tbl[11] = '{20'h00020,  3, 1, 0, 0, 4'h5, 2'd2};
        tbl[12] = '{20'h00000,  3, 0, 0, 0, 4'h5, 2'd2};
        tbl[13] = '{20'h08000, 10, REP_ON ? 4 : 1, 0, 0, 4'hF, 2'd2};
        tbl[14] = '{20'h00000,  3, 0, 0, 0, 4'hF, 2'd2};
        tbl[15] = '{20'h10000, 10, 0, 1, 0, 4'hF, 2'd0};
        tbl[16] = '{20'h00000,  3, 0, 0, 0, 4'hF, 2'd0};

        model_reset();
        keys = '0;
        do_reset();

        for (int i = 0; i < 17; i++) begin
            bh = act_hex; bo = act_op; be = act_eq;
            run(tbl[i].mask, tbl[i].frames);
            check_int($sformatf("vec%0d_newhex_count", i), act_hex - bh, tbl[i].n_hex);
            check_int($sformatf("vec%0d_newop_count", i), act_op - bo, tbl[i].n_op);
            check_int($sformatf("vec%0d_eq_count", i), act_eq - be, tbl[i].n_eq);
            check_int($sformatf("vec%0d_hexcode", i), int'(kp.hexcode), int'(tbl[i].hc));
            check_int($sformatf("vec%0d_opcode", i), int'(kp.opcode), int'(tbl[i].oc));
        end

        // Reset in the middle of press debounce with the key still held.
        run(20'h00008, 1);
        repeat (8) step();
        do_reset();
        bh = act_hex;
        run(20'h00008, 4);
        check_int("reset_redebounce_newhex_count", act_hex - bh, 1);
        check_int("reset_redebounce_hexcode", int'(kp.hexcode), 3);
        run(20'h00000, 3);

        rmask = '0;
        for (int f = 0; f < 160; f++) begin
            if ($urandom_range(0, 9) >= 6) begin
                int r, a, b;
                r = $urandom_range(0, 99);
                a = $urandom_range(0, 19);
                b = (a + 1 + $urandom_range(0, 18)) % 20;
                if (r < 25) rmask = '0;
                else if (r < 85) rmask = 20'(1) << a;
                else rmask = (20'(1) << a) | (20'(1) << b);
            end
            run(rmask, 1);
        end
        run(20'h00000, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
